operand_fetch: RTL and testbench

Issue stage between decode and execute in the npc core. Drives the register file's two combinational read ports, tracks in-flight destination registers in a 32-entry scoreboard, and stalls on RAW/WAW hazards. Optionally bypasses same-cycle writeback data. Latches resolved operands into a single valid/ready pipeline register feeding EX.

---
 rtl/operand_fetch.sv | 127 ++++++++++++
 tb/tb_operand_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Issue stage: reads the register file, stalls on RAW/WAW against the pending-write scoreboard, registers operands for EX.
// Optional macro OPERAND_FETCH_BYPASS_EN forwards same-cycle writeback data into the operands.
module operand_fetch #(
    parameter int XLEN  = 64,
    parameter int CTRLW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic             in_rd_wen,
    input  logic [CTRLW-1:0] in_ctrl,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    input  logic             wb_valid,
    input  logic             wb_wen,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_src1,
    output logic [XLEN-1:0]  out_src2,
    output logic [4:0]       out_rd,
    output logic             out_rd_wen,
    output logic [CTRLW-1:0] out_ctrl
);

    logic [31:0]      r_pend;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_pc, r_out_imm, r_out_src1, r_out_src2;
    logic [4:0]       r_out_rd;
    logic             r_out_rd_wen;
    logic [CTRLW-1:0] r_out_ctrl;

    logic             w_byp1, w_byp2, w_blk1, w_blk2, w_waw, w_hazard;
    logic             w_in_ready, w_accept;
    logic [XLEN-1:0]  w_src1, w_src2;
    logic [31:0]      w_set, w_clr, w_pend_next;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    always_comb begin
        w_byp1 = 1'b0;
        w_byp2 = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
        w_byp1 = wb_valid && wb_wen && (wb_rd == in_rs1);
        w_byp2 = wb_valid && wb_wen && (wb_rd == in_rs2);
`endif
        w_blk1 = r_pend[in_rs1] && !w_byp1;
        w_blk2 = r_pend[in_rs2] && !w_byp2;
        // A retiring writer of the same rd releases its slot this cycle, so WAW need not wait.
        w_waw  = in_rd_wen && r_pend[in_rd] && !(wb_valid && (wb_rd == in_rd));
        w_hazard   = (in_use_rs1 && w_blk1) || (in_use_rs2 && w_blk2) || w_waw;
        w_in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
        w_accept   = in_valid && w_in_ready;

        if (in_rs1 == 5'd0)  w_src1 = '0;
        else if (w_byp1)     w_src1 = wb_data;
        else                 w_src1 = rf_rdata1;
        if (in_rs2 == 5'd0)  w_src2 = '0;
        else if (w_byp2)     w_src2 = wb_data;
        else                 w_src2 = rf_rdata2;

        w_set = '0;
        w_clr = '0;
        if (w_accept && in_rd_wen && (in_rd != 5'd0)) w_set[in_rd] = 1'b1;
        if (wb_valid) w_clr[wb_rd] = 1'b1;
        if (flush && r_out_valid && r_out_rd_wen) w_clr[r_out_rd] = 1'b1;
        w_pend_next = ((r_pend & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    end

    assign in_ready = w_in_ready;

    // Output register stage feeding EX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= '0;
            r_out_valid  <= 1'b0;
            r_out_pc     <= '0;
            r_out_imm    <= '0;
            r_out_src1   <= '0;
            r_out_src2   <= '0;
            r_out_rd     <= '0;
            r_out_rd_wen <= 1'b0;
            r_out_ctrl   <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_pc     <= in_pc;
                r_out_imm    <= in_imm;
                r_out_src1   <= w_src1;
                r_out_src2   <= w_src2;
                r_out_rd     <= in_rd;
                r_out_rd_wen <= in_rd_wen;
                r_out_ctrl   <= in_ctrl;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_pc;
    assign out_imm    = r_out_imm;
    assign out_src1   = r_out_src1;
    assign out_src2   = r_out_src2;
    assign out_rd     = r_out_rd;
    assign out_rd_wen = r_out_rd_wen;
    assign out_ctrl   = r_out_ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-file model; expectations follow the build's bypass setting.
module tb_operand_fetch;

    localparam int XLEN  = 64;
    localparam int CTRLW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [XLEN-1:0]  in_pc, in_imm;
    logic [4:0]       in_rs1, in_rs2, in_rd;
    logic             in_use_rs1, in_use_rs2, in_rd_wen;
    logic [CTRLW-1:0] in_ctrl;
    logic [4:0]       rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]  rf_rdata1, rf_rdata2;
    logic             wb_valid, wb_wen;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_pc, out_imm, out_src1, out_src2;
    logic [4:0]       out_rd;
    logic             out_rd_wen;
    logic [CTRLW-1:0] out_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    logic [XLEN-1:0] rf [32];

    always #5 clk = ~clk;

    // Register file model; x0 reads back garbage so the DUT's zeroing is observable.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= XLEN'(64'h1000 + i);
        end else if (wb_valid && wb_wen && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end
    assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 64'hBAD0 : rf[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 64'hBAD0 : rf[rf_raddr2];

    operand_fetch #(.XLEN(XLEN), .CTRLW(CTRLW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd_wen(in_rd_wen),
        .in_ctrl(in_ctrl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_src1(out_src1), .out_src2(out_src2),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_ctrl(out_ctrl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_pc = '0; in_imm = '0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_rd_wen = 0; in_ctrl = '0;
        wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = '0; flush = 0;
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [4:0] rd, input logic wen);
        in_valid = 1; in_pc = pc; in_imm = pc + 64'h5; in_rd = rd; in_rd_wen = wen;
        in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    endtask

    task automatic test_reset();
        rst = 1; out_ready = 1; idle();
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_pc !== '0) begin n_bad++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        n_cmp++; if (out_src1 !== '0) begin n_bad++; $display("FAIL reset_out_src1 got %h want 0", out_src1); end
        n_cmp++; if (dut.r_pend !== 32'h0) begin n_bad++; $display("FAIL reset_pend got %h want 0", dut.r_pend); end
        rst = 0; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_issue();
        issue(64'h100, 5'd5, 1'b1); in_imm = 64'h55; in_ctrl = 16'hA5A5; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL issue_in_ready got %0b want 1", in_ready); end
        tick(); idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL issue_out_valid got %0b want 1", out_valid); end
        n_cmp++; if (out_imm !== 64'h55) begin n_bad++; $display("FAIL issue_out_imm got %h want 55", out_imm); end
        n_cmp++; if (out_pc !== 64'h100) begin n_bad++; $display("FAIL issue_out_pc got %h want 100", out_pc); end
        n_cmp++; if (out_ctrl !== 16'hA5A5) begin n_bad++; $display("FAIL issue_out_ctrl got %h want a5a5", out_ctrl); end
        n_cmp++; if (dut.r_pend[5] !== 1'b1) begin n_bad++; $display("FAIL issue_pend5 got %0b want 1", dut.r_pend[5]); end
    endtask

    task automatic test_dependent();
        issue(64'h104, 5'd6, 1'b1); in_rs1 = 5; in_use_rs1 = 1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL dep_stall got %0b want 0", in_ready); end
        tick(); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL dep_stall2 got %0b want 0", in_ready); end
        wb_valid = 1; wb_wen = 1; wb_rd = 5; wb_data = 64'h1234; #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dep_wb_cycle_ready got %0b want 1", in_ready); end
        tick();
        wb_valid = 0; wb_wen = 0; in_valid = 0;
`else
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL dep_wb_cycle_ready got %0b want 0", in_ready); end
        tick();
        wb_valid = 0; wb_wen = 0; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dep_next_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 0;
`endif
        n_cmp++; if (out_src1 !== 64'h1234) begin n_bad++; $display("FAIL dep_src1 got %h want 1234", out_src1); end
        n_cmp++; if (out_pc !== 64'h104) begin n_bad++; $display("FAIL dep_pc got %h want 104", out_pc); end
        n_cmp++; if (dut.r_pend !== 32'h40) begin n_bad++; $display("FAIL dep_pend got %h want 40", dut.r_pend); end
        wb_valid = 1; wb_wen = 1; wb_rd = 6; wb_data = 64'h66;
        tick(); idle();
        n_cmp++; if (dut.r_pend !== 32'h0) begin n_bad++; $display("FAIL dep_release_pend got %h want 0", dut.r_pend); end
    endtask

    task automatic test_zero_reg();
        issue(64'h108, 5'd0, 1'b0); in_rs1 = 0; in_use_rs1 = 1; in_rs2 = 3; in_use_rs2 = 1;
        wb_valid = 1; wb_wen = 1; wb_rd = 0; wb_data = 64'hDEAD; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got %0b want 1", in_ready); end
        tick(); idle();
        n_cmp++; if (out_src1 !== '0) begin n_bad++; $display("FAIL zero_src1 got %h want 0", out_src1); end
        n_cmp++; if (out_src2 !== 64'h1003) begin n_bad++; $display("FAIL zero_src2 got %h want 1003", out_src2); end
        n_cmp++; if (dut.r_pend[0] !== 1'b0) begin n_bad++; $display("FAIL zero_pend0 got %0b want 0", dut.r_pend[0]); end
    endtask

    task automatic test_backpressure();
        tick();
        issue(64'h200, 5'd0, 1'b0);
        tick();
        out_ready = 0; issue(64'h300, 5'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %0b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h200) begin n_bad++; $display("FAIL bp_hold[%0d] got v=%0b pc=%h want v=1 pc=200", c, out_valid, out_pc); end
            tick();
        end
        out_ready = 1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        tick(); idle();
        n_cmp++; if (out_pc !== 64'h300 || out_imm !== 64'h305) begin n_bad++; $display("FAIL bp_next got pc=%h imm=%h want 300/305", out_pc, out_imm); end
    endtask

    task automatic test_flush();
        issue(64'h400, 5'd7, 1'b1);
        tick();
        n_cmp++; if (out_rd !== 5'd7 || dut.r_pend[7] !== 1'b1) begin n_bad++; $display("FAIL flush_setup got rd=%0d p7=%0b want 7/1", out_rd, dut.r_pend[7]); end
        issue(64'h404, 5'd8, 1'b1); flush = 1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        tick(); idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (dut.r_pend !== 32'h0) begin n_bad++; $display("FAIL flush_pend got %h want 0", dut.r_pend); end
    endtask

    task automatic test_release_reuse();
        issue(64'h500, 5'd9, 1'b1);
        tick();
        issue(64'h504, 5'd9, 1'b1); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL waw_stall got %0b want 0", in_ready); end
        wb_valid = 1; wb_wen = 0; wb_rd = 9; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL waw_release_ready got %0b want 1", in_ready); end
        tick(); idle();
        n_cmp++; if (out_pc !== 64'h504 || out_valid !== 1'b1) begin n_bad++; $display("FAIL waw_accept got pc=%h v=%0b want 504/1", out_pc, out_valid); end
        n_cmp++; if (dut.r_pend !== 32'h200) begin n_bad++; $display("FAIL waw_pend got %h want 200", dut.r_pend); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            issue(64'h600 + 64'(4 * k), 5'(10 + k), 1'b1); #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %0b want 1", k, in_ready); end
            tick();
            n_cmp++; if (out_pc !== 64'h600 + 64'(4 * k)) begin n_bad++; $display("FAIL b2b_pc[%0d] got %h want %h", k, out_pc, 64'h600 + 64'(4 * k)); end
        end
        idle();
        n_cmp++; if (dut.r_pend !== 32'h1E00) begin n_bad++; $display("FAIL b2b_pend got %h want 1e00", dut.r_pend); end
    endtask

    task automatic test_mid_reset();
        rst = 1;
        tick();
        rst = 0;
        n_cmp++; if (dut.r_pend !== 32'h0 || out_valid !== 1'b0 || out_pc !== '0) begin n_bad++; $display("FAIL midrst got pend=%h v=%0b pc=%h want 0/0/0", dut.r_pend, out_valid, out_pc); end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_dependent();
        test_zero_reg();
        test_backpressure();
        test_flush();
        test_release_reuse();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
